// File: rtl/tick_trap_responder.sv
// Memory-mapped countdown timer that raises a trap on expiry and is acked by the core's trap-entry store.
// Optional prescaler at +5 is compiled in with TICK_PRESCALE_EN.
`ifndef TRAP_ADDR
`define TRAP_ADDR 32'h0000_0200
`endif

module tick_trap_responder #(
  parameter logic [31:0] BASE      = 32'h0000_0100,
  parameter logic [31:0] TRAP_ADDR = `TRAP_ADDR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        strobe,
  input  logic        rw,
  input  logic [31:0] addr,
  inout  wire  [31:0] data,
  output logic        trap
);

`ifdef TICK_PRESCALE_EN
  localparam logic [7:0] MAPPED = 8'b0011_1111;
`else
  localparam logic [7:0] MAPPED = 8'b0001_1111;
`endif

  logic [2:0]  ctrl_reg, ctrl_next;
  logic [31:0] reload_reg, reload_next;
  logic [31:0] count_reg, count_next;
  logic        exp_reg, exp_next;
  logic [31:0] epc_reg, epc_next;
  logic        trap_reg, trap_next;
  logic        tick;

  logic        in_window;
  logic [2:0]  offset;
  logic [7:0]  sel;
  logic [7:0]  wr_sel;
  logic        hit;
  logic        ack;
  logic        rd_en;
  logic [31:0] rdata;

  assign in_window = (addr[31:3] == BASE[31:3]);
  assign offset    = addr[2:0];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_decode
      assign sel[gi] = strobe && in_window && (offset == gi) && MAPPED[gi];
    end
  endgenerate

  assign hit    = |sel;
  assign wr_sel = sel & {8{rw}};
  assign ack    = strobe && rw && (addr == TRAP_ADDR);

`ifdef TICK_PRESCALE_EN
  logic [7:0] prescale_reg, prescale_next;
  logic [7:0] div_reg, div_next;

  assign tick = ctrl_reg[0] && (div_reg == prescale_reg);

  always_comb begin
    prescale_next = prescale_reg;
    div_next      = div_reg + 8'd1;
    if (wr_sel[5]) begin
      prescale_next = data[7:0];
    end
    // Any write to CTRL or PRESCALE restarts the divider so the first period is full length.
    if (wr_sel[0] || wr_sel[5] || !ctrl_reg[0] || tick) begin
      div_next = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_reg <= 8'd0;
      div_reg      <= 8'd0;
    end else begin
      prescale_reg <= prescale_next;
      div_reg      <= div_next;
    end
  end
`else
  assign tick = ctrl_reg[0];
`endif

  always_comb begin
    rdata = 32'd0;
    case (offset)
      3'd0:    rdata = {29'd0, ctrl_reg};
      3'd1:    rdata = reload_reg;
      3'd2:    rdata = count_reg;
      3'd3:    rdata = {31'd0, exp_reg};
      3'd4:    rdata = epc_reg;
`ifdef TICK_PRESCALE_EN
      3'd5:    rdata = {24'd0, prescale_reg};
`endif
      default: rdata = 32'd0;
    endcase
  end

  assign rd_en = hit && !rw && reset_n;
  assign data  = rd_en ? rdata : {32{1'bz}};
  assign trap  = trap_reg;

  // Order matters: ack and STATUS clear first so an expiry on the same edge wins,
  // then bus writes last so they override the counter's own updates.
  always_comb begin
    ctrl_next   = ctrl_reg;
    reload_next = reload_reg;
    count_next  = count_reg;
    exp_next    = exp_reg;
    epc_next    = epc_reg;
    trap_next   = trap_reg;

    if (ack) begin
      trap_next = 1'b0;
      epc_next  = data;
    end
    if (wr_sel[3] && data[0]) begin
      exp_next = 1'b0;
    end

    if (tick) begin
      if (count_reg != 32'd0) begin
        count_next = count_reg - 32'd1;
      end else begin
        exp_next = 1'b1;
        if (ctrl_reg[2]) begin
          trap_next = 1'b1;
        end
        if (ctrl_reg[1]) begin
          count_next = reload_reg;
        end else begin
          ctrl_next[0] = 1'b0;
        end
      end
    end

    if (wr_sel[0]) begin
      ctrl_next = data[2:0];
    end
    if (wr_sel[1]) begin
      reload_next = data;
    end
    if (wr_sel[2]) begin
      count_next = data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_reg   <= 3'd0;
      reload_reg <= 32'd0;
      count_reg  <= 32'd0;
      exp_reg    <= 1'b0;
      epc_reg    <= 32'd0;
      trap_reg   <= 1'b0;
    end else begin
      ctrl_reg   <= ctrl_next;
      reload_reg <= reload_next;
      count_reg  <= count_next;
      exp_reg    <= exp_next;
      epc_reg    <= epc_next;
      trap_reg   <= trap_next;
    end
  end

endmodule
